issue_ctrl_n: RTL and testbench

ISSUE_CTRL_N -- requirements
Module: issue_ctrl_n

---
 rtl/issue_pkg.sv | 21 ++
 rtl/issue_scoreboard.sv | 64 ++++++
 rtl/issue_ctrl_n.sv | 151 +++++++++++++++
 tb/tb_issue_ctrl_n.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
`default_nettype none
// ============================================================================
// issue_pkg : shared constants and helpers for the issue control block.
// Rev 1.0
// ============================================================================
package issue_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam int ISSUE_W_DEFAULT  = 2;
  localparam int LOAD_LAT_DEFAULT = 2;

  // r0 is hardwired to zero, so it can never form a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// issue_scoreboard : shift register of in-flight load destinations, with
// per-slot source-operand hit detection.
// Rev 1.0
// ============================================================================
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int ISSUE_W  = ISSUE_W_DEFAULT,
  parameter int LOAD_LAT = LOAD_LAT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 shift_en,
  input  logic                 clear,
  input  logic                 load_vld,
  input  logic [4:0]           load_rd,
  input  logic [5*ISSUE_W-1:0] rs,
  input  logic [5*ISSUE_W-1:0] rt,
  output logic [ISSUE_W-1:0]   hit
);

  logic [LOAD_LAT-1:0]   vld_q, vld_d;
  logic [5*LOAD_LAT-1:0] rd_q, rd_d;

  always_comb begin
    vld_d = vld_q;
    rd_d  = rd_q;
    if (shift_en) begin
      for (int s = LOAD_LAT - 1; s > 0; s--) begin
        vld_d[s]        = vld_q[s-1];
        rd_d[5*s +: 5]  = rd_q[5*(s-1) +: 5];
      end
      vld_d[0]  = load_vld && (load_rd != 5'd0);
      rd_d[4:0] = load_rd;
    end
    // Clear wins over both shift and hold.
    if (clear) vld_d = '0;
  end

  always_comb begin
    hit = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      for (int s = 0; s < LOAD_LAT; s++) begin
        if (vld_q[s] && (reg_match(rd_q[5*s +: 5], rs[5*k +: 5]) ||
                         reg_match(rd_q[5*s +: 5], rt[5*k +: 5])))
          hit[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      rd_q  <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/issue_ctrl_n.sv
`default_nettype none
// ============================================================================
// issue_ctrl_n : in-order multi-issue grant with load-use scoreboard and HILO
// interlock. Macro ISSUE_PERF_CNT_EN adds saturating performance counters.
// Rev 1.0
// ============================================================================
module issue_ctrl_n
  import issue_pkg::*;
#(
  parameter int ISSUE_W  = ISSUE_W_DEFAULT,
  parameter int LOAD_LAT = LOAD_LAT_DEFAULT,
  parameter int CNT_W    = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [CNT_W-1:0]             fifo_cnt,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [5*ISSUE_W-1:0]         inst_rs,
  input  logic [5*ISSUE_W-1:0]         inst_rt,
  input  logic [5*ISSUE_W-1:0]         inst_rd,
  input  logic [ISSUE_W-1:0]           inst_wb_en,
  input  logic [ISSUE_W-1:0]           inst_branch,
  input  logic [ISSUE_W-1:0]           inst_priv,
  input  logic [ISSUE_W-1:0]           inst_hilo,
  input  logic [ISSUE_W-1:0]           inst_mdiv,
  input  logic [2*ISSUE_W-1:0]         inst_mem_type,
  input  logic                         div_done,
  output logic [ISSUE_W-1:0]           issue_en,
  output logic [$clog2(ISSUE_W+1)-1:0] issue_cnt
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_full_cnt,
  output logic [31:0]                  perf_hazard_cnt
`endif
);

  localparam int CW = $clog2(ISSUE_W + 1);

  logic               hilo_busy_q, hilo_busy_d;
  logic [ISSUE_W-1:0] sb_hit;
  logic               load_vld;
  logic [4:0]         load_rd;
  logic               mdiv_issue;
  logic [31:0]        fifo_ext;
  logic               any_priv, any_mem, any_hilo, slot_ok;
  logic [4:0]         rs_k, rt_k, rd_j;

  assign fifo_ext = 32'(fifo_cnt);

  issue_scoreboard #(
    .ISSUE_W  (ISSUE_W),
    .LOAD_LAT (LOAD_LAT)
  ) u_scoreboard (
    .clk      (clk),
    .resetn   (resetn),
    .shift_en (!stall),
    .clear    (flush),
    .load_vld (load_vld),
    .load_rd  (load_rd),
    .rs       (inst_rs),
    .rt       (inst_rt),
    .hit      (sb_hit)
  );

  // Grant is built slot by slot so each slot sees the accumulated state of the older ones.
  always_comb begin
    issue_en = '0;
    any_priv = 1'b0;
    any_mem  = 1'b0;
    any_hilo = 1'b0;
    slot_ok  = 1'b0;
    rs_k     = '0;
    rt_k     = '0;
    rd_j     = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      rs_k    = inst_rs[5*k +: 5];
      rt_k    = inst_rt[5*k +: 5];
      slot_ok = (fifo_ext > 32'(k)) && !stall && !flush && !sb_hit[k] &&
                !(inst_hilo[k] && hilo_busy_q);
      if (k > 0) begin
        slot_ok = slot_ok && issue_en[k-1] && !inst_branch[k] && !inst_priv[k] && !any_priv &&
                  !(any_mem && (inst_mem_type[2*k +: 2] != MEM_NONE)) &&
                  !(any_hilo && inst_hilo[k]);
        for (int j = 0; j < k; j++) begin
          rd_j = inst_rd[5*j +: 5];
          if (inst_wb_en[j] && (reg_match(rd_j, rs_k) || reg_match(rd_j, rt_k)))
            slot_ok = 1'b0;
        end
      end
      issue_en[k] = slot_ok;
      any_priv    = any_priv | inst_priv[k];
      any_mem     = any_mem | (inst_mem_type[2*k +: 2] != MEM_NONE);
      any_hilo    = any_hilo | inst_hilo[k];
    end
  end

  always_comb begin
    load_vld   = 1'b0;
    load_rd    = '0;
    mdiv_issue = 1'b0;
    issue_cnt  = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (issue_en[k]) begin
        issue_cnt  = issue_cnt + CW'(1);
        mdiv_issue = mdiv_issue | inst_mdiv[k];
        if (inst_mem_type[2*k +: 2] == MEM_LOAD) begin
          load_vld = 1'b1;
          load_rd  = inst_rd[5*k +: 5];
        end
      end
    end
    hilo_busy_d = hilo_busy_q;
    if (mdiv_issue)    hilo_busy_d = 1'b1;
    else if (div_done) hilo_busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) hilo_busy_q <= 1'b0;
    else         hilo_busy_q <= hilo_busy_d;
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_full_q, perf_full_d, perf_hazard_q, perf_hazard_d;

  always_comb begin
    perf_full_d   = perf_full_q;
    perf_hazard_d = perf_hazard_q;
    if ((issue_cnt == CW'(ISSUE_W)) && (perf_full_q != 32'hFFFF_FFFF))
      perf_full_d = perf_full_q + 32'd1;
    if ((fifo_ext != 32'd0) && !stall && !flush && (issue_cnt == '0) &&
        (perf_hazard_q != 32'hFFFF_FFFF))
      perf_hazard_d = perf_hazard_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_full_q   <= '0;
      perf_hazard_q <= '0;
    end else begin
      perf_full_q   <= perf_full_d;
      perf_hazard_q <= perf_hazard_d;
    end
  end

  assign perf_full_cnt   = perf_full_q;
  assign perf_hazard_cnt = perf_hazard_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_ctrl_n.sv
`default_nettype none
// ============================================================================
// tb_issue_ctrl_n : two configurations (W=2/LAT=2, W=4/LAT=3) driven with
// directed and random slot contents, checked against a tick-based model.
// Rev 1.0
// ============================================================================
module tb_issue_ctrl_n;
  import issue_pkg::*;

  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  logic       clk = 1'b0, resetn = 1'b0, stall = 1'b0, flush = 1'b0, div_done = 1'b0;
  logic [3:0] fifo_cnt = '0;

  logic [9:0]  a_rs, a_rt, a_rd;
  logic [1:0]  a_wb, a_br, a_pv, a_hl, a_md, a_en, a_cnt;
  logic [3:0]  a_mt;
  logic [19:0] b_rs, b_rt, b_rd;
  logic [3:0]  b_wb, b_br, b_pv, b_hl, b_md, b_en;
  logic [7:0]  b_mt;
  logic [2:0]  b_cnt;

  // Slot contents shared by both instances; instance A sees slots 0..1.
  logic [4:0] s_rs[4], s_rt[4], s_rd[4];
  logic       s_wb[4], s_br[4], s_pv[4], s_hl[4], s_md[4];
  logic [1:0] s_mt[4];

  // Model: a register is unreadable until the non-stalled tick count reaches ready_tick.
  int ready_tick[2][32];
  int tick;
  bit div_pend[2];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  issue_ctrl_n #(.ISSUE_W(2), .LOAD_LAT(LAT_A), .CNT_W(4)) u_dut_a (
    .clk(clk), .resetn(resetn), .fifo_cnt(fifo_cnt), .stall(stall), .flush(flush),
    .inst_rs(a_rs), .inst_rt(a_rt), .inst_rd(a_rd), .inst_wb_en(a_wb),
    .inst_branch(a_br), .inst_priv(a_pv), .inst_hilo(a_hl), .inst_mdiv(a_md),
    .inst_mem_type(a_mt), .div_done(div_done), .issue_en(a_en), .issue_cnt(a_cnt)
  );

  issue_ctrl_n #(.ISSUE_W(4), .LOAD_LAT(LAT_B), .CNT_W(4)) u_dut_b (
    .clk(clk), .resetn(resetn), .fifo_cnt(fifo_cnt), .stall(stall), .flush(flush),
    .inst_rs(b_rs), .inst_rt(b_rt), .inst_rd(b_rd), .inst_wb_en(b_wb),
    .inst_branch(b_br), .inst_priv(b_pv), .inst_hilo(b_hl), .inst_mdiv(b_md),
    .inst_mem_type(b_mt), .div_done(div_done), .issue_en(b_en), .issue_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) ready_tick[i][r] = 0;
      div_pend[i] = 1'b0;
    end
    tick = 0;
  endtask

  function automatic bit blocked(input int inst, input logic [4:0] r);
    return (r != 5'd0) && (tick < ready_tick[inst][r]);
  endfunction

  function automatic bit slot_can(input int inst, input int k);
    if (int'(fifo_cnt) <= k || stall || flush) return 1'b0;
    if (blocked(inst, s_rs[k]) || blocked(inst, s_rt[k])) return 1'b0;
    if (s_hl[k] && div_pend[inst]) return 1'b0;
    if (k > 0) begin
      if (s_br[k] || s_pv[k]) return 1'b0;
      for (int j = 0; j < k; j++) begin
        if (s_pv[j]) return 1'b0;
        if (s_mt[j] != 2'b00 && s_mt[k] != 2'b00) return 1'b0;
        if (s_hl[j] && s_hl[k]) return 1'b0;
        if (s_wb[j] && s_rd[j] != 5'd0 && (s_rd[j] == s_rs[k] || s_rd[j] == s_rt[k])) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic int model_n(input int inst, input int w);
    int n = 0;
    for (int k = 0; k < w; k++) begin
      if (!slot_can(inst, k)) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_update(input int inst, input int n, input int lat);
    bit mdiv = 1'b0;
    if (flush) begin
      for (int r = 0; r < 32; r++) ready_tick[inst][r] = 0;
    end else if (!stall) begin
      for (int k = 0; k < n; k++)
        if (s_mt[k] == MEM_LOAD && s_rd[k] != 5'd0) ready_tick[inst][s_rd[k]] = tick + lat + 1;
    end
    for (int k = 0; k < n; k++) mdiv = mdiv | s_md[k];
    if (mdiv)          div_pend[inst] = 1'b1;
    else if (div_done) div_pend[inst] = 1'b0;
  endtask

  task automatic apply();
    for (int k = 0; k < 4; k++) begin
      b_rs[5*k +: 5] = s_rs[k];  b_rt[5*k +: 5] = s_rt[k];  b_rd[5*k +: 5] = s_rd[k];
      b_wb[k] = s_wb[k]; b_br[k] = s_br[k]; b_pv[k] = s_pv[k]; b_hl[k] = s_hl[k]; b_md[k] = s_md[k];
      b_mt[2*k +: 2] = s_mt[k];
      if (k < 2) begin
        a_rs[5*k +: 5] = s_rs[k];  a_rt[5*k +: 5] = s_rt[k];  a_rd[5*k +: 5] = s_rd[k];
        a_wb[k] = s_wb[k]; a_br[k] = s_br[k]; a_pv[k] = s_pv[k]; a_hl[k] = s_hl[k]; a_md[k] = s_md[k];
        a_mt[2*k +: 2] = s_mt[k];
      end
    end
  endtask

  task automatic clear_slots();
    for (int k = 0; k < 4; k++) begin
      s_rs[k] = '0; s_rt[k] = '0; s_rd[k] = '0; s_mt[k] = MEM_NONE;
      s_wb[k] = 1'b0; s_br[k] = 1'b0; s_pv[k] = 1'b0; s_hl[k] = 1'b0; s_md[k] = 1'b0;
    end
  endtask

  task automatic set_slot(input int k, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic wb, input logic [1:0] mt);
    s_rs[k] = rs; s_rt[k] = rt; s_rd[k] = rd; s_wb[k] = wb; s_mt[k] = mt;
  endtask

  // Called at a falling edge with inputs set; checks model (and optional constants), then advances.
  task automatic cycle(input string tag, input logic [1:0] exp_a, input bit chk_a,
                       input logic [3:0] exp_b, input bit chk_b);
    int na, nb;
    apply();
    #1;
    na = model_n(0, 2);
    nb = model_n(1, 4);
    check({tag, "/a_en"},  32'(a_en),  32'((1 << na) - 1));
    check({tag, "/a_cnt"}, 32'(a_cnt), 32'(na));
    check({tag, "/b_en"},  32'(b_en),  32'((1 << nb) - 1));
    check({tag, "/b_cnt"}, 32'(b_cnt), 32'(nb));
    if (chk_a) check({tag, "/a_const"}, 32'(a_en), 32'(exp_a));
    if (chk_b) check({tag, "/b_const"}, 32'(b_en), 32'(exp_b));
    @(posedge clk);
    if (resetn) begin
      model_update(0, na, LAT_A);
      model_update(1, nb, LAT_B);
      if (!stall) tick++;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    clear_slots();
    @(negedge clk);

    cycle("rst_empty", 2'b00, 1, 4'b0000, 1);
    fifo_cnt = 4'd2;
    cycle("rst_fifo2", 2'b11, 1, 4'b0011, 1);
    resetn = 1'b1;

    set_slot(0, 5'd1, 5'd2, 5'd3, 1'b1, MEM_NONE);
    set_slot(1, 5'd4, 5'd5, 5'd6, 1'b1, MEM_NONE);
    cycle("indep", 2'b11, 1, 4'b0011, 1);
    fifo_cnt = 4'd15;
    cycle("full", 2'b11, 1, 4'b1111, 1);
    stall = 1'b1;
    cycle("stall", 2'b00, 1, 4'b0000, 1);
    stall = 1'b0;

    clear_slots(); fifo_cnt = 4'd1;
    set_slot(0, 5'd1, 5'd2, 5'd5, 1'b1, MEM_LOAD);
    cycle("ld_r5", 2'b01, 1, 4'b0001, 1);
    set_slot(0, 5'd5, 5'd0, 5'd6, 1'b1, MEM_NONE);
    cycle("ld_use1", 2'b00, 1, 4'b0000, 1);
    cycle("ld_use2", 2'b00, 1, 4'b0000, 1);
    cycle("ld_use3", 2'b01, 1, 4'b0000, 1);
    cycle("ld_use4", 2'b01, 1, 4'b0001, 1);

    clear_slots(); fifo_cnt = 4'd2;
    set_slot(0, 5'd1, 5'd2, 5'd3, 1'b1, MEM_NONE);
    set_slot(1, 5'd4, 5'd3, 5'd6, 1'b1, MEM_NONE);
    cycle("raw_r3", 2'b01, 1, 4'b0001, 1);
    s_rd[0] = 5'd0; s_rt[1] = 5'd0;
    cycle("raw_r0", 2'b11, 1, 4'b0011, 1);
    s_br[1] = 1'b1;
    cycle("branch1", 2'b01, 1, 4'b0001, 1);
    s_br[1] = 1'b0; s_pv[0] = 1'b1;
    cycle("priv0", 2'b01, 1, 4'b0001, 1);

    clear_slots(); fifo_cnt = 4'd1;
    s_hl[0] = 1'b1; s_md[0] = 1'b1;
    cycle("mdiv", 2'b01, 1, 4'b0001, 1);
    s_md[0] = 1'b0;
    cycle("mfhi_w1", 2'b00, 1, 4'b0000, 1);
    cycle("mfhi_w2", 2'b00, 1, 4'b0000, 1);
    div_done = 1'b1;
    cycle("mfhi_done", 2'b00, 1, 4'b0000, 1);
    div_done = 1'b0;
    cycle("mfhi_go", 2'b01, 1, 4'b0001, 1);

    clear_slots();
    set_slot(0, 5'd1, 5'd2, 5'd7, 1'b1, MEM_LOAD);
    cycle("ld_r7", 2'b01, 1, 4'b0001, 1);
    set_slot(0, 5'd7, 5'd0, 5'd8, 1'b1, MEM_NONE);
    flush = 1'b1;
    cycle("flush", 2'b00, 1, 4'b0000, 1);
    flush = 1'b0;
    cycle("post_flush", 2'b01, 1, 4'b0001, 1);

    clear_slots(); fifo_cnt = 4'd3;
    cycle("fifo3", 2'b11, 1, 4'b0111, 1);
    set_slot(1, 5'd1, 5'd2, 5'd0, 1'b0, MEM_STORE);
    set_slot(2, 5'd3, 5'd4, 5'd9, 1'b1, MEM_LOAD);
    cycle("two_mem", 2'b11, 1, 4'b0011, 1);

    for (int i = 0; i < 3000; i++) begin
      resetn = ($urandom_range(0, 399) != 0);
      if (!resetn) model_reset();
      stall    = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      div_done = ($urandom_range(0, 7) == 0);
      fifo_cnt = 4'($urandom_range(0, 6));
      for (int k = 0; k < 4; k++) begin
        s_rs[k] = 5'($urandom_range(0, 7));
        s_rt[k] = 5'($urandom_range(0, 7));
        s_rd[k] = 5'($urandom_range(0, 7));
        s_wb[k] = 1'($urandom_range(0, 1));
        s_br[k] = ($urandom_range(0, 9) == 0);
        s_pv[k] = ($urandom_range(0, 14) == 0);
        s_hl[k] = ($urandom_range(0, 5) == 0);
        s_md[k] = s_hl[k] && 1'($urandom_range(0, 1));
        s_mt[k] = 2'($urandom_range(0, 2));
      end
      cycle("rnd", 2'b00, 0, 4'b0000, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
